// File: rtl/sad_accumulator_if.sv
// Sample/result handshake bundle for sad_accumulator.
// master: the block's environment (drives samples, clear and out_ready).
// slave:  the accumulator itself.
// Signals:
//   clear      synchronous window abort
//   in_valid   / in_ready   sample handshake; in_a, in_b unsigned pixels
//   out_valid  / out_ready  result handshake; out_sum window SAD, out_sat clamp flag
interface sad_accumulator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 12
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sum;
  logic              out_sat;

  modport master (
    output clear, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences accumulator.
// Each accepted sample contributes |in_a - in_b|; every WIN samples the window sum is
// presented on out_sum with a valid/ready handshake. Two-stage pipeline: stage 1 registers
// the absolute difference, stage 2 adds it into the running accumulator.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      sad_accumulator_if.slave (clear, sample and result handshakes)
// Build option: define SAD_SATURATE_EN to clamp the accumulator at 2^OUT_W-1 and report
// the clamp on out_sat; otherwise the accumulator wraps and out_sat is tied low.
module sad_accumulator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 9,
  parameter int unsigned OUT_W  = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  sad_accumulator_if.slave    bus
);

  localparam int unsigned CntW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIN - 1);

  // Output state: StFull means out_sum holds an unconsumed result.
  localparam logic StIdle = 1'b0;
  localparam logic StFull = 1'b1;

  logic              state_q, state_d;
  logic [DATA_W-1:0] s1_diff_q, s1_diff_d;
  logic              s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_sum_q, out_sum_d;

  logic              in_ready;
  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] abs_diff;
  logic [OUT_W-1:0]  add_val;
  logic              add_sat;

  assign in_ready = (state_q == StIdle) | bus.out_ready;
  assign accept   = bus.in_valid & in_ready & ~bus.clear;
  assign complete = s1_valid_q & (cnt_q == CntLast);
  assign abs_diff = (bus.in_a >= bus.in_b) ? (bus.in_a - bus.in_b) : (bus.in_b - bus.in_a);

`ifdef SAD_SATURATE_EN
  logic             sat_q, sat_d;        // sticky: some add in this window clamped
  logic             out_sat_q, out_sat_d;
  logic [OUT_W:0]   sum_wide;

  always_comb begin
    sum_wide = {1'b0, acc_q} + (OUT_W + 1)'(s1_diff_q);
    add_val  = sum_wide[OUT_W] ? {OUT_W{1'b1}} : sum_wide[OUT_W-1:0];
    add_sat  = sat_q | sum_wide[OUT_W];
  end
`else
  always_comb begin
    add_val = acc_q + OUT_W'(s1_diff_q);
    add_sat = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    s1_diff_d  = s1_diff_q;
    s1_valid_d = accept;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
`ifdef SAD_SATURATE_EN
    sat_d      = sat_q;
    out_sat_d  = out_sat_q;
`endif

    if (accept) begin
      s1_diff_d = abs_diff;
    end

    if (s1_valid_q) begin
      if (complete) begin
        out_sum_d = add_val;
        acc_d     = '0;
        cnt_d     = '0;
`ifdef SAD_SATURATE_EN
        out_sat_d = add_sat;
        sat_d     = 1'b0;
`endif
      end else begin
        acc_d = add_val;
        cnt_d = cnt_q + CntW'(1);
`ifdef SAD_SATURATE_EN
        sat_d = add_sat;
`endif
      end
    end

    // A new completion reloads the result even while the old one is being consumed.
    case (state_q)
      StIdle:  if (complete) state_d = StFull;
      StFull:  if (!complete && bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // clear beats acceptance and completion; out_sum keeps its last value.
    if (bus.clear) begin
      state_d    = StIdle;
      s1_valid_d = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
      out_sum_d  = out_sum_q;
`ifdef SAD_SATURATE_EN
      sat_d      = 1'b0;
      out_sat_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      s1_diff_q  <= '0;
      s1_valid_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
`ifdef SAD_SATURATE_EN
      sat_q      <= 1'b0;
      out_sat_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s1_diff_q  <= s1_diff_d;
      s1_valid_q <= s1_valid_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_sum_q  <= out_sum_d;
`ifdef SAD_SATURATE_EN
      sat_q      <= sat_d;
      out_sat_q  <= out_sat_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StFull);
  assign bus.out_sum   = out_sum_q;
`ifdef SAD_SATURATE_EN
  assign bus.out_sat   = out_sat_q;
`else
  assign bus.out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_sad_accumulator.sv
// Bench for sad_accumulator: WIN=4, DATA_W=8, OUT_W=10 main instance, plus an OUT_W=9
// instance for the clamp/wrap case. Reference model keeps the list of accepted
// differences per window and a queue of scheduled results.
module tb_sad_accumulator;
  localparam int Win    = 4;
  localparam int MaxSum = 1023;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  sad_accumulator_if #(.DATA_W(8), .OUT_W(10)) bus ();
  sad_accumulator_if #(.DATA_W(8), .OUT_W(9))  bus9 ();

  sad_accumulator #(.DATA_W(8), .WIN(4), .OUT_W(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sad_accumulator #(.DATA_W(8), .WIN(4), .OUT_W(9)) dut9 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus9)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;
  int n_acc    = 0;

  // Reference model state.
  int m_win[$];
  int p_edge[$];
  int p_sum[$];
  bit p_sat[$];
  bit m_ov;
  int m_sum;
  bit m_sat;

  task automatic model_clear();
    m_win.delete();
    p_edge.delete();
    p_sum.delete();
    p_sat.delete();
    m_ov  = 1'b0;
    m_sat = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_sum = 0;
  endtask

  // Advance one clock edge and update the model; returns at edge + 1.
  task automatic tick();
    bit acc, hs, clr;
    int d, total;
    acc = reset_n && bus.in_valid && (!m_ov || bus.out_ready) && !bus.clear;
    hs  = m_ov && bus.out_ready;
    clr = bus.clear;
    d   = (int'(bus.in_a) > int'(bus.in_b)) ? int'(bus.in_a) - int'(bus.in_b)
                                          : int'(bus.in_b) - int'(bus.in_a);
    @(posedge clock);
    edge_no++;
    if (!reset_n) begin
      model_reset();
    end else if (clr) begin
      model_clear();
    end else begin
      if (hs) m_ov = 1'b0;
      if (p_edge.size() > 0 && p_edge[0] == edge_no) begin
        void'(p_edge.pop_front());
        m_ov  = 1'b1;
        m_sum = p_sum.pop_front();
        m_sat = p_sat.pop_front();
      end
      if (acc) begin
        n_acc++;
        m_win.push_back(d);
        if (m_win.size() == Win) begin
          total = 0;
          foreach (m_win[i]) total += m_win[i];
`ifdef SAD_SATURATE_EN
          p_sum.push_back(total > MaxSum ? MaxSum : total);
          p_sat.push_back(total > MaxSum);
`else
          p_sum.push_back(total % (MaxSum + 1));
          p_sat.push_back(1'b0);
`endif
          p_edge.push_back(edge_no + 1);
          m_win.delete();
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
    bus9.clear = 0; bus9.in_valid = 0; bus9.in_a = 0; bus9.in_b = 0; bus9.out_ready = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    tick();
    tick();
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd0) $display("FAIL reset_out_sum got %0d want 0", bus.out_sum); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat got %b want 0", bus.out_sat); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus9.out_valid !== 1'b0) $display("FAIL reset_out_valid9 got %b want 0", bus9.out_valid); else n_pass++;
    tick();
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_basic();
    logic [7:0] av [4] = '{8'd10, 8'd3, 8'd0, 8'd255};
    logic [7:0] bv [4] = '{8'd3, 8'd10, 8'd0, 8'd0};
    apply_reset();
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_a = av[i]; bus.in_b = bv[i];
      tick();
    end
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", bus.out_valid); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd269) $display("FAIL basic_sum got %0d want 269", bus.out_sum); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_one_cycle got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd269) $display("FAIL basic_sum_kept got %0d want 269", bus.out_sum); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit seen;
    apply_reset();
    n_acc = 0;
    bus.out_ready = 0; bus.in_valid = 1; bus.in_a = 8'd200; bus.in_b = 8'd0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid_held got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd800) $display("FAIL bp_sum_held got %0d want 800", bus.out_sum); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (n_acc >= 8) $display("FAIL bp_stalled accepted %0d want below 8", n_acc); else n_pass++;
    bus.out_ready = 1;
    for (int i = 0; i < 10 && n_acc < 8; i++) tick();
    bus.in_valid = 0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = bus.out_valid;
    end
    n_checks++; if (!seen) $display("FAIL bp_second_window got no out_valid want 1"); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd800) $display("FAIL bp_second_sum got %0d want 800", bus.out_sum); else n_pass++;
  endtask

  task automatic test_saturate();
    apply_reset();
    bus9.out_ready = 1; bus9.in_valid = 1; bus9.in_a = 8'd255; bus9.in_b = 8'd0;
    for (int i = 0; i < 4; i++) tick();
    bus9.in_valid = 0;
    tick();
    n_checks++; if (bus9.out_valid !== 1'b1) $display("FAIL sat_valid got %b want 1", bus9.out_valid); else n_pass++;
`ifdef SAD_SATURATE_EN
    n_checks++; if (bus9.out_sum !== 9'd511) $display("FAIL sat_sum got %0d want 511", bus9.out_sum); else n_pass++;
    n_checks++; if (bus9.out_sat !== 1'b1) $display("FAIL sat_flag got %b want 1", bus9.out_sat); else n_pass++;
`else
    n_checks++; if (bus9.out_sum !== 9'd508) $display("FAIL wrap_sum got %0d want 508", bus9.out_sum); else n_pass++;
    n_checks++; if (bus9.out_sat !== 1'b0) $display("FAIL wrap_flag got %b want 0", bus9.out_sat); else n_pass++;
`endif
    bus9.out_ready = 0;
  endtask

  task automatic test_clear();
    bit seen;
    apply_reset();
    bus.out_ready = 1;
    bus.in_valid = 1; bus.in_a = 8'd50; bus.in_b = 8'd7;
    tick();
    tick();
    bus.in_valid = 0; bus.clear = 1;
    tick();
    bus.clear = 0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clear_valid got %b want 0", bus.out_valid); else n_pass++;
    bus.in_valid = 1; bus.in_a = 8'd1; bus.in_b = 8'd2;
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = bus.out_valid;
    end
    n_checks++; if (!seen) $display("FAIL clear_window got no out_valid want 1"); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd4) $display("FAIL clear_sum got %0d want 4", bus.out_sum); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] av [4] = '{8'd1, 8'd7, 8'd20, 8'd0};
    logic [7:0] bv [4] = '{8'd5, 8'd7, 8'd0, 8'd100};
    apply_reset();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_a = 8'd9; bus.in_b = 8'd2;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_pre_valid got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd28) $display("FAIL rmid_pre_sum got %0d want 28", bus.out_sum); else n_pass++;
    bus.in_valid = 0;
    #2;
    reset_n = 0;
    model_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd0) $display("FAIL rmid_sum got %0d want 0", bus.out_sum); else n_pass++;
    n_checks++; if (bus.out_sat !== 1'b0) $display("FAIL rmid_sat got %b want 0", bus.out_sat); else n_pass++;
    tick();
    #2;
    reset_n = 1;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_a = av[i]; bus.in_b = bv[i];
      tick();
    end
    bus.in_valid = 0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_post_valid got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_sum !== 10'd124) $display("FAIL rmid_post_sum got %0d want 124", bus.out_sum); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int fails_before;
    apply_reset();
    fails_before = n_checks - n_pass;
    for (int c = 0; c < 120; c++) begin
      bus.in_valid  = 1;
      bus.in_a      = 8'($urandom_range(0, 255));
      bus.in_b      = 8'($urandom_range(0, 255));
      bus.out_ready = (c % 3) != 0;
      #1;
      n_checks++;
      if (bus.in_ready !== (!m_ov || bus.out_ready))
        $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, bus.in_ready, !m_ov || bus.out_ready);
      else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== m_ov) $display("FAIL b2b_valid cycle %0d got %b want %b", c, bus.out_valid, m_ov); else n_pass++;
      n_checks++; if (bus.out_sum !== 10'(m_sum)) $display("FAIL b2b_sum cycle %0d got %0d want %0d", c, bus.out_sum, m_sum); else n_pass++;
      if (n_checks - n_pass > fails_before + 5) break;
    end
  endtask

  task automatic test_random();
    int fails_before;
    apply_reset();
    fails_before = n_checks - n_pass;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_a      = 8'($urandom_range(0, 255));
      bus.in_b      = 8'($urandom_range(0, 255));
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.clear     = $urandom_range(0, 40) == 0;
      #1;
      n_checks++;
      if (bus.in_ready !== (!m_ov || bus.out_ready))
        $display("FAIL rnd_in_ready cycle %0d got %b want %b", c, bus.in_ready, !m_ov || bus.out_ready);
      else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== m_ov) $display("FAIL rnd_valid cycle %0d got %b want %b", c, bus.out_valid, m_ov); else n_pass++;
      n_checks++; if (bus.out_sum !== 10'(m_sum)) $display("FAIL rnd_sum cycle %0d got %0d want %0d", c, bus.out_sum, m_sum); else n_pass++;
      n_checks++; if (bus.out_sat !== m_sat) $display("FAIL rnd_sat cycle %0d got %b want %b", c, bus.out_sat, m_sat); else n_pass++;
      if (n_checks - n_pass > fails_before + 5) break;
    end
    bus.clear = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturate();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sad_accumulator.md
SAD_ACCUMULATOR -- requirements
Module: sad_accumulator

Interface
REQ-001 Parameter DATA_W, default 8, width of each input pixel operand.
REQ-002 Parameter WIN, default 9, samples per window; legal range 2..256.
REQ-003 Parameter OUT_W, default 12, width of the accumulated sum; legal range is OUT_W >= DATA_W.
REQ-004 Port clock  input  1  rising-edge clock for all state.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port clear  input  1  synchronous window abort; discards all partial and pending results.
REQ-007 Port in_valid  input  1  in_a/in_b carry a sample.
REQ-008 Port in_ready  output  1  block accepts a sample this cycle.
REQ-009 Port in_a  input  DATA_W  left-image pixel, unsigned.
REQ-010 Port in_b  input  DATA_W  right-image pixel, unsigned.
REQ-011 Port out_valid  output  1  out_sum holds a completed window sum.
REQ-012 Port out_ready  input  1  consumer takes out_sum this cycle.
REQ-013 Port out_sum  output  OUT_W  sum of |in_a-in_b| over one window, unsigned.
REQ-014 Port out_sat  output  1  saturation flag for the current out_sum.

Function
REQ-015 A sample shall be accepted on a rising edge where in_valid and in_ready are both 1 and clear is 0.
REQ-016 in_ready shall be combinational and equal to (~out_valid | out_ready).
REQ-017 Stage 1 shall register |in_a-in_b| (DATA_W bits, no sign) and a stage-1 valid flag on the acceptance edge.
REQ-018 Stage 2 shall add a valid stage-1 value into acc (OUT_W bits) on the next edge, and increment a sample counter cnt (0..WIN-1).
REQ-019 When stage 2 adds the sample at cnt==WIN-1, the block shall load acc+diff into out_sum, set out_valid=1, reset acc to 0, and reset cnt to 0 on the same edge.
REQ-020 The latency from acceptance of a window's last sample to out_valid=1 shall be 2 edges.
REQ-021 The block shall accept back-to-back samples at one per cycle with no bubble between windows.
REQ-022 Output handshake: out_valid and out_sum shall hold stable while out_valid=1 and out_ready=0. out_valid shall clear on an edge with out_ready=1 unless a new window completes on that same edge, in which case the new sum is loaded.
REQ-023 Stage-1 data accepted while out_valid is pending shall still be accumulated. Because WIN>=2, no window can complete while a previous result is pending.
REQ-024 Output state machine: IDLE (out_valid=0) -> FULL on window completion. FULL -> IDLE on out_ready with no completion. FULL -> FULL on out_ready with completion, or on no out_ready.
REQ-025 clear=1 shall zero acc, cnt, the stage-1 valid flag, out_valid and out_sat on the next edge, and shall take priority over acceptance and completion in the same cycle.
REQ-026 out_sum shall keep its last value after clear or handshake; only out_valid qualifies it.

Reset
REQ-027 While reset_n=0, acc, cnt, the stage-1 register and valid, out_sum, out_valid and out_sat shall be 0 immediately, without waiting for clock.
REQ-028 Reset asserted mid-window shall discard the partial window; the first sample accepted after release starts a new window at cnt=0.

Configuration
REQ-029 With macro SAD_SATURATE_EN defined, any stage-2 sum exceeding 2^OUT_W-1 shall clamp acc to 2^OUT_W-1 and set a sticky window flag. That flag shall be copied to out_sat on completion and cleared with acc.
REQ-030 Without SAD_SATURATE_EN, acc shall wrap modulo 2^OUT_W and out_sat shall be constant 0.

Verification
REQ-031 WIN=4, DATA_W=8, OUT_W=10; samples (10,3),(3,10),(0,0),(255,0) back-to-back with out_ready=1 -> out_sum=269 and out_valid=1 for exactly one cycle, 2 edges after the 4th acceptance.
REQ-032 Same configuration, 8 continuous samples of (200,0), out_ready=0 -> first out_sum=800 is held, in_ready=0 after its completion, the 8th sample is not accepted until out_ready=1, and the second window then gives out_sum=800.
REQ-033 Same configuration, OUT_W=9, 4 samples of (255,0) -> with SAD_SATURATE_EN out_sum=511 and out_sat=1; without it out_sum=508 and out_sat=0.
REQ-034 clear pulsed after 2 samples of a window, then 4 samples of (1,2) -> out_sum=4, with no contribution from the pre-clear samples.
REQ-035 reset_n driven low between clock edges mid-window with out_valid=1 -> all outputs 0 immediately, and the next full window sums correctly from cnt=0.
REQ-036 out_ready=1 on the same edge that the next window completes (in_valid held, out_ready toggling) -> out_valid stays 1 and out_sum updates to the new sum with no lost window.
